// File: rtl/ex_mdu.sv
// Iterative RV32M-style multiply/divide unit beside the EX-stage ALU.
// Holds the pipeline via mdu_stall and presents a registered result while mdu_done is high.
module ex_mdu #(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mdu_start_ex,
   input  logic [2:0]      mdu_code_ex,
   input  logic [XLEN-1:0] rs1_sel,
   input  logic [XLEN-1:0] rs2_sel,
   input  logic            ext_stall,
   input  logic            rst_pipe,
   output logic            mdu_stall,
   output logic            mdu_done,
   output logic [XLEN-1:0] mdu_result
);

   localparam int              CW       = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]   MUL_LAST = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
   localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? neg(v) : v;
   endfunction

   state_t            state_r, state_next_s;
   logic              done_r, done_next_s;
   logic [XLEN-1:0]   result_r, result_next_s;
   logic [XLEN-1:0]   op_a_r, op_b_r, quo_r, rem_r, dvs_r;
   logic [1:0]        code_r;
   logic [CW-1:0]     cnt_r;
   logic              sign_q_r, sign_r_r;

   logic              accept_s, div_signed_s, div_zero_s, div_ovf_s, special_s;
   logic [XLEN-1:0]   special_res_s;
   logic [XLEN-1:0]   mul_a_s, mul_b_s, mul_res_s;
   logic [1:0]        mul_code_s;
   logic              a_sgn_s, b_sgn_s;
   logic [2*XLEN-1:0] mul_a_ext_s, mul_b_ext_s, prod_s;
   logic [XLEN:0]     shift_s;
   logic              ge_s;
   logic [XLEN-1:0]   quo_step_s, rem_step_s, fix_q_s, fix_r_s, fix_res_s;

   // Start acceptance and divide special-case detection on live operands
   always_comb begin
      accept_s     = (state_r == S_IDLE) & mdu_start_ex & ~rst_pipe;
      div_signed_s = mdu_code_ex[2] & ~mdu_code_ex[0];
      div_zero_s   = (rs2_sel == ZERO);
      div_ovf_s    = div_signed_s & (rs1_sel == SMIN) & (rs2_sel == ONES);
      special_s    = mdu_code_ex[2] & (div_zero_s | div_ovf_s);
      if (div_zero_s) begin
         special_res_s = mdu_code_ex[1] ? rs1_sel : ONES;
      end else begin
         special_res_s = mdu_code_ex[1] ? ZERO : rs1_sel;
      end
   end

   // Multiplier; uses live operands in IDLE so a single-cycle latency can finish at accept
   always_comb begin
      if (state_r == S_IDLE) begin
         mul_a_s    = rs1_sel;
         mul_b_s    = rs2_sel;
         mul_code_s = mdu_code_ex[1:0];
      end else begin
         mul_a_s    = op_a_r;
         mul_b_s    = op_b_r;
         mul_code_s = code_r;
      end
      a_sgn_s     = (mul_code_s == 2'b01) | (mul_code_s == 2'b10);
      b_sgn_s     = (mul_code_s == 2'b01);
      mul_a_ext_s = {{XLEN{a_sgn_s & mul_a_s[XLEN-1]}}, mul_a_s};
      mul_b_ext_s = {{XLEN{b_sgn_s & mul_b_s[XLEN-1]}}, mul_b_s};
      prod_s      = mul_a_ext_s * mul_b_ext_s;
      mul_res_s   = (mul_code_s == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
   end

   // Restoring divide step and final sign correction
   always_comb begin
      shift_s    = {rem_r, quo_r[XLEN-1]};
      ge_s       = (shift_s >= {1'b0, dvs_r});
      rem_step_s = ge_s ? (shift_s[XLEN-1:0] - dvs_r) : shift_s[XLEN-1:0];
      quo_step_s = {quo_r[XLEN-2:0], ge_s};
      fix_q_s    = sign_q_r ? neg(quo_r) : quo_r;
      fix_r_s    = sign_r_r ? neg(rem_r) : rem_r;
      fix_res_s  = code_r[1] ? fix_r_s : fix_q_s;
   end

   // Next state and next registered outputs; a flush overrides everything
   always_comb begin
      state_next_s  = state_r;
      result_next_s = result_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               if (!mdu_code_ex[2]) begin
                  if (MUL_LAT == 1) begin
                     state_next_s  = S_DONE;
                     result_next_s = mul_res_s;
                  end else begin
                     state_next_s = S_MUL;
                  end
               end else if (special_s) begin
                  state_next_s  = S_DONE;
                  result_next_s = special_res_s;
               end else begin
                  state_next_s = S_DIV;
               end
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_MUL: begin
            if (cnt_r == MUL_LAST) begin
               state_next_s  = S_DONE;
               result_next_s = mul_res_s;
            end else begin
               state_next_s = S_MUL;
            end
         end
         S_DIV: begin
            if (cnt_r == DIV_LAST) begin
               state_next_s = S_FIX;
            end else begin
               state_next_s = S_DIV;
            end
         end
         S_FIX: begin
            state_next_s  = S_DONE;
            result_next_s = fix_res_s;
         end
         S_DONE: begin
            if (ext_stall) begin
               state_next_s = S_DONE;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         default: state_next_s = S_IDLE;
      endcase
      if (rst_pipe) begin
         state_next_s  = S_IDLE;
         result_next_s = ZERO;
      end else begin
         result_next_s = result_next_s;
      end
      done_next_s = (state_next_s == S_DONE);
   end

   assign mdu_stall  = rst_n & (accept_s | (state_r == S_MUL) | (state_r == S_DIV) | (state_r == S_FIX));
   assign mdu_done   = done_r;
   assign mdu_result = result_r;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= S_IDLE;
         done_r   <= 1'b0;
         result_r <= ZERO;
      end else begin
         state_r  <= state_next_s;
         done_r   <= done_next_s;
         result_r <= result_next_s;
      end
   end

   // Operand capture, cycle counting and divider iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_r   <= ZERO;
         op_b_r   <= ZERO;
         quo_r    <= ZERO;
         rem_r    <= ZERO;
         dvs_r    <= ZERO;
         code_r   <= 2'b00;
         cnt_r    <= CNT_ZERO;
         sign_q_r <= 1'b0;
         sign_r_r <= 1'b0;
      end else if (rst_pipe) begin
         op_a_r   <= ZERO;
         op_b_r   <= ZERO;
         quo_r    <= ZERO;
         rem_r    <= ZERO;
         dvs_r    <= ZERO;
         code_r   <= 2'b00;
         cnt_r    <= CNT_ZERO;
         sign_q_r <= 1'b0;
         sign_r_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  op_a_r   <= rs1_sel;
                  op_b_r   <= rs2_sel;
                  code_r   <= mdu_code_ex[1:0];
                  cnt_r    <= CNT_ZERO;
                  quo_r    <= mag(rs1_sel, div_signed_s);
                  dvs_r    <= mag(rs2_sel, div_signed_s);
                  rem_r    <= ZERO;
                  sign_q_r <= div_signed_s & (rs1_sel[XLEN-1] ^ rs2_sel[XLEN-1]);
                  sign_r_r <= div_signed_s & rs1_sel[XLEN-1];
               end
            end
            S_MUL: cnt_r <= cnt_r + CNT_ONE;
            S_DIV: begin
               cnt_r <= cnt_r + CNT_ONE;
               quo_r <= quo_step_s;
               rem_r <= rem_step_s;
            end
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu (XLEN=32, MUL_LAT=2).
module tb_ex_mdu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mdu_start_ex;
   logic [2:0]  mdu_code_ex;
   logic [31:0] rs1_sel;
   logic [31:0] rs2_sel;
   logic        ext_stall;
   logic        rst_pipe;
   logic        mdu_stall;
   logic        mdu_done;
   logic [31:0] mdu_result;

   int n_assert = 0;
   int n_fail   = 0;

   ex_mdu #(.XLEN(32), .MUL_LAT(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mdu_start_ex (mdu_start_ex),
      .mdu_code_ex  (mdu_code_ex),
      .rs1_sel      (rs1_sel),
      .rs2_sel      (rs2_sel),
      .ext_stall    (ext_stall),
      .rst_pipe     (rst_pipe),
      .mdu_stall    (mdu_stall),
      .mdu_done     (mdu_done),
      .mdu_result   (mdu_result)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Leaves the bench in the DONE cycle with start still high.
   task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
      int lat;
      int stalls;
      mdu_start_ex = 1'b1;
      mdu_code_ex  = code;
      rs1_sel      = a;
      rs2_sel      = b;
      if (mdu_done) step();
      #1;
      chk({tag, " stall at accept"}, {31'd0, mdu_stall}, 32'd1);
      lat    = 0;
      stalls = 0;
      while (!mdu_done && lat < 100) begin
         if (mdu_stall) stalls++;
         step();
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " stall cycles"}, stalls, exp_lat);
      chk({tag, " result"}, mdu_result, exp_res);
      chk({tag, " stall in done"}, {31'd0, mdu_stall}, 32'd0);
   endtask

   task automatic leave_done(input string tag);
      mdu_start_ex = 1'b0;
      step();
      chk({tag, " done cleared"}, {31'd0, mdu_done}, 32'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      mdu_start_ex = 1'b1;
      mdu_code_ex  = 3'b000;
      rs1_sel      = 32'd0;
      rs2_sel      = 32'd0;
      ext_stall    = 1'b0;
      rst_pipe     = 1'b0;
      #2;
      chk("reset stall", {31'd0, mdu_stall}, 32'd0);
      chk("reset done", {31'd0, mdu_done}, 32'd0);
      chk("reset result", mdu_result, 32'd0);
      mdu_start_ex = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      run_op("MUL", 3'b000, 32'hFFFFFFFF, 32'h00000002, 2, 32'hFFFFFFFE);
      leave_done("MUL");
      run_op("MULH", 3'b001, 32'hFFFFFFFF, 32'h00000002, 2, 32'hFFFFFFFF);
      leave_done("MULH");
      run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'h00000002, 2, 32'hFFFFFFFF);
      leave_done("MULHSU");
      run_op("MULHU", 3'b011, 32'hFFFFFFFF, 32'h00000002, 2, 32'h00000001);
      leave_done("MULHU");

      run_op("DIV", 3'b100, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFD);
      leave_done("DIV");
      run_op("REM", 3'b110, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF);
      leave_done("REM");
      run_op("DIVU", 3'b101, 32'hFFFFFFF9, 32'h00000002, 34, 32'h7FFFFFFC);
      leave_done("DIVU");
      run_op("REMU", 3'b111, 32'hFFFFFFF9, 32'h00000002, 34, 32'h00000001);
      leave_done("REMU");

      run_op("DIVU by 0", 3'b101, 32'h12345678, 32'h00000000, 1, 32'hFFFFFFFF);
      leave_done("DIVU by 0");
      run_op("REM by 0", 3'b110, 32'h12345678, 32'h00000000, 1, 32'h12345678);
      leave_done("REM by 0");
      run_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
      leave_done("DIV ovf");
      run_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000);
      leave_done("REM ovf");

      // Hold DONE with ext_stall for three extra cycles.
      run_op("hold", 3'b011, 32'hFFFFFFFF, 32'h00000002, 2, 32'h00000001);
      ext_stall    = 1'b1;
      mdu_start_ex = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold done", {31'd0, mdu_done}, 32'd1);
         chk("hold result", mdu_result, 32'h00000001);
         chk("hold stall", {31'd0, mdu_stall}, 32'd0);
      end
      ext_stall = 1'b0;
      step();
      chk("hold release done", {31'd0, mdu_done}, 32'd0);

      // Flush in the middle of a divide.
      mdu_start_ex = 1'b1;
      mdu_code_ex  = 3'b101;
      rs1_sel      = 32'd1000;
      rs2_sel      = 32'd3;
      step();
      for (int i = 0; i < 10; i++) step();
      chk("flush pre stall", {31'd0, mdu_stall}, 32'd1);
      rst_pipe     = 1'b1;
      mdu_start_ex = 1'b0;
      step();
      rst_pipe = 1'b0;
      #1;
      chk("flush stall", {31'd0, mdu_stall}, 32'd0);
      chk("flush done", {31'd0, mdu_done}, 32'd0);
      chk("flush result", mdu_result, 32'd0);
      for (int i = 0; i < 30; i++) step();
      chk("flush no late done", {31'd0, mdu_done}, 32'd0);
      run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 34, 32'd14);
      leave_done("DIVU 100/7");

      // Start together with a flush in IDLE is rejected.
      mdu_start_ex = 1'b1;
      mdu_code_ex  = 3'b000;
      rs1_sel      = 32'd3;
      rs2_sel      = 32'd5;
      rst_pipe     = 1'b1;
      #1;
      chk("reject stall", {31'd0, mdu_stall}, 32'd0);
      step();
      mdu_start_ex = 1'b0;
      rst_pipe     = 1'b0;
      #1;
      chk("reject not busy", {31'd0, mdu_stall}, 32'd0);
      step();
      step();
      chk("reject no done", {31'd0, mdu_done}, 32'd0);

      // Asynchronous reset in the middle of a multiply.
      run_op("pre-reset DIVU", 3'b101, 32'd100, 32'd7, 34, 32'd14);
      leave_done("pre-reset DIVU");
      mdu_start_ex = 1'b1;
      mdu_code_ex  = 3'b000;
      rs1_sel      = 32'd3;
      rs2_sel      = 32'd5;
      step();
      chk("mid-mul stall", {31'd0, mdu_stall}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst stall", {31'd0, mdu_stall}, 32'd0);
      chk("async rst done", {31'd0, mdu_done}, 32'd0);
      chk("async rst result", mdu_result, 32'd0);
      mdu_start_ex = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      run_op("b2b MUL", 3'b000, 32'd3, 32'd5, 2, 32'd15);
      run_op("b2b DIVU", 3'b101, 32'd15, 32'd4, 34, 32'd3);
      leave_done("b2b DIVU");
      step();
      chk("b2b no extra done", {31'd0, mdu_done}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Parametrised iterative multiply/divide unit that extends the execution stage with the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), generalised to an XLEN-bit datapath. It sits beside the EX-stage ALU and takes post-forwarding operands from the EX selectors. It holds the pipeline through `mdu_stall` while a multi-cycle operation runs. When `mdu_done` is high, it presents the result in place of the ALU result, so the EX→MA register captures it.

## Interface
- `XLEN`, 32, datapath width in bits; even, ≥8.
- `MUL_LAT`, 2, multiply latency in cycles, legal range 1..4.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mdu_start_ex`  in  1  an M-extension instruction is valid in EX. Already gated with `~jmp_purge_ma`.
- `mdu_code_ex`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_sel`  in  XLEN  forwarded rs1 operand.
- `rs2_sel`  in  XLEN  forwarded rs2 operand.
- `ext_stall`  in  1  stall from any source other than this block.
- `rst_pipe`  in  1  synchronous pipeline flush.
- `mdu_stall`  out  1  combinational; requests a pipeline hold.
- `mdu_done`  out  1  registered; result valid this cycle.
- `mdu_result`  out  XLEN  registered result; valid while `mdu_done`=1.

## Operation
- States:
  - IDLE
  - MUL: counts MUL_LAT-1 cycles.
  - DIV: XLEN iterations.
  - FIX: sign correction.
  - DONE
- Start is accepted only in IDLE, when `mdu_start_ex`=1 and `rst_pipe`=0. At acceptance, capture the operands and code.
- In DONE, `mdu_start_ex` is ignored: it still shows the completing instruction.
- IDLE→MUL on a multiply code.
  - The 2·XLEN product is formed from the captured operands.
  - Operands are sign- or zero-extended per op: MULH s×s, MULHSU s×u, MULHU u×u, MUL either.
  - MUL returns the low XLEN bits; the other three return the high XLEN bits.
  - For MUL_LAT=1 the transition goes straight to DONE.
- IDLE→DIV on a divide code with normal operands.
  - Restoring division on operand magnitudes, 1 quotient bit per cycle, MSB first.
  - Magnitude = two's-complement absolute value for signed ops (DIV, REM); operand as-is for unsigned.
  - Record sign_q = s1^s2 and sign_r = s1, each for signed ops only.
  - DIV→FIX after XLEN iterations.
  - FIX negates the quotient if sign_q and the remainder if sign_r; then →DONE.
- Special cases go IDLE→DONE directly, computed from the live operands:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all-ones, DIV/REM): DIV returns rs1; REM returns 0.
- DONE→IDLE when `ext_stall`=0. With `ext_stall`=1, stay in DONE; `mdu_done` and `mdu_result` hold.
- `mdu_stall` = (IDLE & `mdu_start_ex` & ~`rst_pipe`) | MUL | DIV | FIX. It is 0 in DONE.
- `rst_pipe` in any state → IDLE on the next edge, with `mdu_done`=0 and `mdu_result`=0. An in-flight operation is discarded.
- Reset values: state IDLE, `mdu_done`=0, `mdu_result`=0, all internal registers 0. `mdu_stall`=0 while `rst_n`=0.

## Timing
- Start accepted at edge T (with `mdu_start_ex` high in cycle T-1 ... call the accept cycle C).
- MUL: `mdu_stall` is high in cycles C..C+MUL_LAT-1. DONE is cycle C+MUL_LAT, with `mdu_done`=1 and `mdu_stall`=0.
- DIV, normal case: DONE at C+XLEN+2, i.e. 34 cycles after C for XLEN=32. `mdu_stall` is high in C..C+XLEN+1.
- Special cases: DONE at C+1.
- The EX→MA register loads `mdu_result` on the edge that ends DONE with `ext_stall`=0.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after DONE. There is no extra bubble.
- If `rst_pipe` and `mdu_start_ex` are both high in IDLE, the start is rejected, and `mdu_stall` stays 0.

## Test plan
- Multiply, XLEN=32, MUL_LAT=2, rs1=0xFFFFFFFF, rs2=0x00000002:
  - MUL → 0xFFFFFFFE.
  - MULH → 0xFFFFFFFF.
  - MULHSU → 0xFFFFFFFF.
  - MULHU → 0x00000001.
  - In every case `mdu_done` comes 2 cycles after accept, with `mdu_stall` high for exactly 2 cycles.
- Divide, rs1=-7 (0xFFFFFFF9), rs2=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
  - In every case `mdu_done` comes 34 cycles after accept.
- Divide-by-zero and overflow:
  - rs1=0x12345678, rs2=0: DIVU → 0xFFFFFFFF, REM → 0x12345678.
  - rs1=0x80000000, rs2=0xFFFFFFFF: DIV → 0x80000000, REM → 0.
  - All of these give `mdu_done` one cycle after accept.
- `ext_stall` held high for 3 cycles during DONE → `mdu_done` and `mdu_result` stay stable for 4 cycles; state returns to IDLE after `ext_stall` falls.
- `rst_pipe` pulsed in DIV iteration 10 → next cycle: IDLE, `mdu_stall`=0, `mdu_done`=0, `mdu_result`=0. A following DIVU 100/7 then returns 14.
- Asynchronous `rst_n` asserted mid-MUL → outputs go to 0 immediately. Back-to-back MUL 3×5 then DIVU 15/4 after release → results 15 then 3, with no lost or duplicated `mdu_done`.
